// File: rtl/fifo_rd_uart_tx.sv
//------------------------------------------------------------------------------
// fifo_rd_uart_tx
// Read-domain consumer of the asynchronous FIFO. It pops one word whenever it
// is idle, enabled and the FIFO is not empty. It then sends that word as a
// UART frame: start bit, DATA_WIDTH data bits LSB first, an optional parity
// bit, and a stop bit. Each bit lasts CLKS_PER_BIT R_CLK cycles.
//
// Optional feature macro: PARITY_EN
//   When defined, the PAR_TYP port and a parity bit are added.
//   PAR_TYP: 0 = even, 1 = odd.
//
// Ports:
//   R_CLK    in   read-domain clock, rising edge
//   R_RST    in   asynchronous active-low reset
//   RD_DATA  in   FIFO read data at the current read address
//   EMPTY    in   FIFO empty flag
//   TX_EN    in   level enable for new pops
//   PAR_TYP  in   parity type (PARITY_EN only), sampled at the pop edge
//   R_INC    out  combinational pop request
//   TX_OUT   out  registered UART line, idles high
//   BUSY     out  registered, high from the pop edge until the end of stop
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module fifo_rd_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                  R_CLK,
   input  logic                  R_RST,
   input  logic [DATA_WIDTH-1:0] RD_DATA,
   input  logic                  EMPTY,
   input  logic                  TX_EN,
`ifdef PARITY_EN
   input  logic                  PAR_TYP,
`endif
   output logic                  R_INC,
   output logic                  TX_OUT,
   output logic                  BUSY
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DATA_WIDTH - 1);

`ifdef PARITY_EN
   typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
`endif

   // Parity bit: XOR of the data word, inverted for odd parity.
   function automatic logic parity_f(input logic [DATA_WIDTH-1:0] d, input logic typ);
      return (^d) ^ typ;
   endfunction

   state_t                state_r, state_nxt_s;
   logic [CW-1:0]         cnt_r, cnt_nxt_s;
   logic [IW-1:0]         idx_r, idx_nxt_s;
   logic [DATA_WIDTH-1:0] shift_r, shift_nxt_s;
   logic                  tx_r, tx_nxt_s;
   logic                  busy_r, busy_nxt_s;
   logic                  bit_done_s;
   logic                  r_inc_s;
`ifdef PARITY_EN
   logic                  par_typ_r, par_typ_nxt_s;
`endif

   // Pop request: only from IDLE, so the stale EMPTY flag during a frame
   // can never cause a second pop; gated by reset so it is low in reset.
   assign r_inc_s    = (state_r == IDLE) & TX_EN & ~EMPTY & R_RST;
   assign bit_done_s = (cnt_r == CNT_MAX);

   assign R_INC  = r_inc_s;
   assign TX_OUT = tx_r;
   assign BUSY   = busy_r;

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge R_CLK or negedge R_RST) begin
      if (!R_RST) begin
         state_r   <= IDLE;
         cnt_r     <= {CW{1'b0}};
         idx_r     <= {IW{1'b0}};
         shift_r   <= {DATA_WIDTH{1'b0}};
         tx_r      <= 1'b1;
         busy_r    <= 1'b0;
`ifdef PARITY_EN
         par_typ_r <= 1'b0;
`endif
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         idx_r     <= idx_nxt_s;
         shift_r   <= shift_nxt_s;
         tx_r      <= tx_nxt_s;
         busy_r    <= busy_nxt_s;
`ifdef PARITY_EN
         par_typ_r <= par_typ_nxt_s;
`endif
      end
   end

   // Next-state, counters and next line value.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      idx_nxt_s     = idx_r;
      shift_nxt_s   = shift_r;
      busy_nxt_s    = busy_r;
      tx_nxt_s      = 1'b1;
`ifdef PARITY_EN
      par_typ_nxt_s = par_typ_r;
`endif
      case (state_r)
         IDLE: begin
            if (r_inc_s) begin
               shift_nxt_s   = RD_DATA;
               state_nxt_s   = START;
               busy_nxt_s    = 1'b1;
               cnt_nxt_s     = {CW{1'b0}};
               idx_nxt_s     = {IW{1'b0}};
`ifdef PARITY_EN
               par_typ_nxt_s = PAR_TYP;
`endif
            end else begin
               busy_nxt_s = 1'b0;
            end
         end
         START: begin
            if (bit_done_s) begin
               cnt_nxt_s   = {CW{1'b0}};
               idx_nxt_s   = {IW{1'b0}};
               state_nxt_s = DATA;
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end
         DATA: begin
            if (bit_done_s) begin
               cnt_nxt_s = {CW{1'b0}};
               if (idx_r == IDX_MAX) begin
                  idx_nxt_s   = {IW{1'b0}};
`ifdef PARITY_EN
                  state_nxt_s = PARITY;
`else
                  state_nxt_s = STOP;
`endif
               end else begin
                  idx_nxt_s = idx_r + IW'(1);
               end
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end
`ifdef PARITY_EN
         PARITY: begin
            if (bit_done_s) begin
               cnt_nxt_s   = {CW{1'b0}};
               state_nxt_s = STOP;
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end
`endif
         STOP: begin
            if (bit_done_s) begin
               cnt_nxt_s   = {CW{1'b0}};
               state_nxt_s = IDLE;
               busy_nxt_s  = 1'b0;
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end
         default: begin
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
            cnt_nxt_s   = {CW{1'b0}};
            idx_nxt_s   = {IW{1'b0}};
         end
      endcase

      // The line is registered, so it is derived from the state being entered.
      case (state_nxt_s)
         START:   tx_nxt_s = 1'b0;
         DATA:    tx_nxt_s = shift_nxt_s[idx_nxt_s];
`ifdef PARITY_EN
         PARITY:  tx_nxt_s = parity_f(shift_nxt_s, par_typ_nxt_s);
`endif
         default: tx_nxt_s = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_fifo_rd_uart_tx.sv
`timescale 1ns/1ps
module tb_fifo_rd_uart_tx;

   localparam int DW  = 8;
   localparam int CPB = 4;
`ifdef PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int FL = (2 + DW + PB) * CPB;

   logic          R_CLK   = 1'b0;
   logic          R_RST   = 1'b0;
   logic          TX_EN   = 1'b1;
   logic          par_typ = 1'b0;
   logic [DW-1:0] RD_DATA;
   logic          EMPTY;
   logic          R_INC;
   logic          TX_OUT;
   logic          BUSY;

   // Small FIFO model: the read pointer moves on the pop edge, and EMPTY
   // rises two cycles late to mimic the synchroniser lag.
   logic [DW-1:0] mem [0:15];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   int            pops   = 0;
   int            cyc    = 0;
   logic          e_d1   = 1'b1;
   logic          e_d2   = 1'b1;
   logic          real_empty;

   int n_tests = 0;
   int n_fail  = 0;

   assign real_empty = (rd_ptr == wr_ptr);
   assign EMPTY      = real_empty & e_d1 & e_d2;
   assign RD_DATA    = mem[rd_ptr[3:0]];

   always #5 R_CLK = ~R_CLK;

   always @(posedge R_CLK) begin
      cyc  <= cyc + 1;
      e_d1 <= real_empty;
      e_d2 <= e_d1;
      if (R_INC === 1'b1) begin
         rd_ptr <= rd_ptr + 1;
         pops   <= pops + 1;
      end
   end

   fifo_rd_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
      .R_CLK   (R_CLK),
      .R_RST   (R_RST),
      .RD_DATA (RD_DATA),
      .EMPTY   (EMPTY),
      .TX_EN   (TX_EN),
`ifdef PARITY_EN
      .PAR_TYP (par_typ),
`endif
      .R_INC   (R_INC),
      .TX_OUT  (TX_OUT),
      .BUSY    (BUSY)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("%s", tag);
      end
   endtask

   // Expected line value for every cycle of one frame, cycle 0 = first after pop.
   function automatic logic [FL-1:0] exp_tx(input logic [DW-1:0] d, input logic pt);
      logic [FL-1:0] v;
      int b;
      for (int i = 0; i < FL; i++) begin
         b = i / CPB;
         if (b == 0)                        v[i] = 1'b0;
         else if (b <= DW)                  v[i] = d[b-1];
         else if (PB == 1 && b == DW + 1)   v[i] = (^d) ^ pt;
         else                               v[i] = 1'b1;
      end
      return v;
   endfunction

   task automatic wait_pop(input string tag, output int at);
      int n = 0;
      #1;
      while (R_INC !== 1'b1 && n < 200) begin
         @(negedge R_CLK);
         #1;
         n++;
      end
      chk(tag, 64'(R_INC), 64'(1));
      at = cyc;
   endtask

   task automatic frame(input string tag, input logic [DW-1:0] d, input logic pt, input int drop_at);
      logic [FL-1:0] tx_v, busy_v, inc_v;
      for (int i = 0; i < FL; i++) begin
         @(negedge R_CLK);
         tx_v[i]   = TX_OUT;
         busy_v[i] = BUSY;
         inc_v[i]  = R_INC;
         if (i == drop_at) TX_EN = 1'b0;
      end
      chk({tag, "_tx"},   64'(tx_v),   64'(exp_tx(d, pt)));
      chk({tag, "_busy"}, 64'(busy_v), 64'({FL{1'b1}}));
      chk({tag, "_rinc"}, 64'(inc_v),  64'(0));
      @(negedge R_CLK);
      #1;
      chk({tag, "_busy_end"}, 64'(BUSY),   64'(0));
      chk({tag, "_tx_end"},   64'(TX_OUT), 64'(1));
   endtask

   initial begin
      int c0, c1, c2, bad;

      // 1: reset, then idle with an empty FIFO
      R_RST = 1'b0;
      repeat (3) @(negedge R_CLK);
      #1;
      chk("rst_tx",   64'(TX_OUT), 64'(1));
      chk("rst_busy", 64'(BUSY),   64'(0));
      chk("rst_rinc", 64'(R_INC),  64'(0));
      R_RST = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge R_CLK);
         if (R_INC !== 1'b0 || TX_OUT !== 1'b1 || BUSY !== 1'b0) bad++;
      end
      chk("idle_empty", 64'(bad), 64'(0));

      // 2: single word 0xA5
      mem[0] = 8'hA5;
      wr_ptr = 1;
      wait_pop("t2_pop", c0);
      frame("t2", 8'hA5, 1'b0, -1);
      chk("t2_pops", 64'(pops), 64'(1));

      // 3: three queued words, back to back
      mem[1] = 8'h01; mem[2] = 8'hFF; mem[3] = 8'h3C;
      wr_ptr = 4;
      wait_pop("t3_pop0", c0);
      frame("t3a", 8'h01, 1'b0, -1);
      wait_pop("t3_pop1", c1);
      chk("t3_space1", 64'(c1 - c0), 64'(FL + 1));
      frame("t3b", 8'hFF, 1'b0, -1);
      wait_pop("t3_pop2", c2);
      chk("t3_space2", 64'(c2 - c1), 64'(FL + 1));
      frame("t3c", 8'h3C, 1'b0, -1);
      chk("t3_pops",  64'(pops),  64'(4));
      chk("t3_empty", 64'(EMPTY), 64'(1));

      // 4: TX_EN dropped at cycle 10 of a frame
      mem[4] = 8'h96; mem[5] = 8'h5A;
      wr_ptr = 6;
      wait_pop("t4_pop0", c0);
      frame("t4a", 8'h96, 1'b0, 10);
      bad = 0;
      repeat (8) begin
         @(negedge R_CLK);
         if (R_INC !== 1'b0 || BUSY !== 1'b0 || TX_OUT !== 1'b1) bad++;
      end
      chk("t4_inhibit", 64'(bad), 64'(0));
      TX_EN = 1'b1;
      #1;
      chk("t4_resume", 64'(R_INC), 64'(1));
      frame("t4b", 8'h5A, 1'b0, -1);
      chk("t4_pops", 64'(pops), 64'(6));

      // 5: reset at cycle 15 of a frame (line is low on bit 2 of 0xC3)
      mem[6] = 8'hC3; mem[7] = 8'h81;
      wr_ptr = 8;
      wait_pop("t5_pop0", c0);
      repeat (15) @(negedge R_CLK);
      chk("t5_pre_tx", 64'(TX_OUT), 64'(0));
      R_RST = 1'b0;
      #1;
      chk("t5_rst_tx",   64'(TX_OUT), 64'(1));
      chk("t5_rst_busy", 64'(BUSY),   64'(0));
      chk("t5_rst_rinc", 64'(R_INC),  64'(0));
      repeat (2) @(negedge R_CLK);
      R_RST = 1'b1;
      wait_pop("t5_pop1", c1);
      frame("t5", 8'h81, 1'b0, -1);
      chk("t5_pops", 64'(pops), 64'(8));

`ifdef PARITY_EN
      // 6: parity even then odd on 0x07; PAR_TYP changes mid-frame must not matter
      mem[8] = 8'h07; mem[9] = 8'h07;
      par_typ = 1'b0;
      wr_ptr = 10;
      wait_pop("t6_pop0", c0);
      @(posedge R_CLK);
      #1;
      par_typ = 1'b1;
      frame("t6a", 8'h07, 1'b0, -1);
      wait_pop("t6_pop1", c1);
      chk("t6_space", 64'(c1 - c0), 64'(45));
      frame("t6b", 8'h07, 1'b1, -1);
      chk("t6_pops", 64'(pops), 64'(10));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
